// File: rtl/bitstream_self_writer.sv
// bitstream_self_writer
// Streams a byte-addressed bitstream image from a synchronous byte memory
// into the fabric self-write port as paced SelfWriteData/SelfWriteStrobe
// words, with length checking, abort, word counting and a running checksum.
module bitstream_self_writer #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 14,
    parameter int SETUP_CYCLES = 2,
    parameter int GAP_CYCLES   = 2,
    parameter bit BIG_ENDIAN   = 1'b1
) (
    input  logic              CLK,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   length,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [DATA_W-1:0] SelfWriteData,
    output logic              SelfWriteStrobe,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count,
    output logic [DATA_W-1:0] checksum
);

    localparam int NB   = DATA_W / 8;
    localparam int LW   = ADDR_W + 1;
    localparam int T1   = (SETUP_CYCLES > NB) ? SETUP_CYCLES : NB;
    localparam int TMAX = (GAP_CYCLES > T1) ? GAP_CYCLES : T1;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] FETCH_LAST = TW'(NB);
    localparam logic [TW-1:0] SETUP_LAST = TW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST   = (GAP_CYCLES > 0) ? TW'(GAP_CYCLES - 1) : '0;
    localparam logic [LW-1:0] MAX_LEN    = LW'(1) << ADDR_W;
    localparam logic [LW-1:0] NB_L       = LW'(NB);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SETUP,
        S_STROBE,
        S_GAP,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     cnt_q, cnt_d;
    logic [LW-1:0]     ptr_q, ptr_d;
    logic [LW-1:0]     len_q, len_d;
    logic [DATA_W-1:0] asm_q, asm_d;
    logic [DATA_W-1:0] swd_q, swd_d;
    logic [LW-1:0]     wc_q, wc_d;
    logic [DATA_W-1:0] cs_q, cs_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] ahold_q, ahold_d;
    logic              strobe;
    logic              len_bad;

    assign len_bad = (length == '0) || ((length % NB_L) != '0) || (length > MAX_LEN);

    // Next-state, datapath updates and per-cycle outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        asm_d   = asm_q;
        swd_d   = swd_q;
        wc_d    = wc_q;
        cs_d    = cs_q;
        err_d   = 1'b0;
        mem_rd  = 1'b0;
        strobe  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len_bad) begin
                        err_d = 1'b1;
                    end else begin
                        wc_d    = '0;
                        cs_d    = '0;
                        ptr_d   = '0;
                        len_d   = length;
                        cnt_d   = '0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (cnt_q != FETCH_LAST) begin
                    mem_rd = 1'b1;
                    ptr_d  = ptr_q + 1'b1;
                end
                // byte read at count k-1 arrives at count k; lane depends on byte order
                for (int unsigned i = 0; i < NB; i++) begin
                    if (cnt_q == TW'(BIG_ENDIAN ? (NB - i) : (i + 1))) begin
                        asm_d[i*8 +: 8] = mem_rdata;
                    end
                end
                if (cnt_q == FETCH_LAST) begin
                    swd_d   = asm_d;
                    cnt_d   = '0;
                    state_d = S_SETUP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_STROBE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STROBE: begin
                strobe = 1'b1;
                wc_d   = wc_q + 1'b1;
                cs_d   = cs_q + swd_q;
                cnt_d  = '0;
                if (ptr_q == len_q) begin
                    state_d = S_DONE;
                end else if (GAP_CYCLES == 0) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // abort overrides everything above: no strobe, counters and word frozen
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            strobe  = 1'b0;
            wc_d    = wc_q;
            cs_d    = cs_q;
            swd_d   = swd_q;
        end

        mem_addr = mem_rd ? ptr_q[ADDR_W-1:0] : ahold_q;
        ahold_d  = mem_addr;
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            len_q   <= '0;
            asm_q   <= '0;
            swd_q   <= '0;
            wc_q    <= '0;
            cs_q    <= '0;
            err_q   <= 1'b0;
            ahold_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            asm_q   <= asm_d;
            swd_q   <= swd_d;
            wc_q    <= wc_d;
            cs_q    <= cs_d;
            err_q   <= err_d;
            ahold_q <= ahold_d;
        end
    end

    assign SelfWriteData   = swd_q;
    assign SelfWriteStrobe = strobe;
    assign busy            = (state_q != S_IDLE);
    assign done            = (state_q == S_DONE);
    assign error           = err_q;
    assign word_count      = wc_q;
    assign checksum        = cs_q;

endmodule

// File: tb/tb_bitstream_self_writer.sv
// Self-checking bench for bitstream_self_writer: three configurations
// (defaults; 16-bit little-endian with 4-bit addresses; fast pacing).
// Expected strobes (data and cycle) go into per-instance scoreboards.
module tb_bitstream_self_writer;

    logic CLK = 1'b0;
    logic resetn = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] data;
        int          at;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    exp_t ma, mb, mc;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [16];

    // instance A: defaults
    logic        a_start = 1'b0, a_abort = 1'b0;
    logic [14:0] a_len = '0;
    logic        a_rd;
    logic [13:0] a_addr;
    logic [7:0]  a_rdata = '0;
    logic [31:0] a_data, a_cs;
    logic        a_stb, a_busy, a_done, a_err;
    logic [14:0] a_wc;

    bitstream_self_writer dut_a (
        .CLK(CLK), .resetn(resetn), .start(a_start), .abort(a_abort), .length(a_len),
        .mem_rd(a_rd), .mem_addr(a_addr), .mem_rdata(a_rdata),
        .SelfWriteData(a_data), .SelfWriteStrobe(a_stb), .busy(a_busy), .done(a_done),
        .error(a_err), .word_count(a_wc), .checksum(a_cs)
    );

    // instance B: 16-bit, little-endian, 16-byte address space
    logic        b_start = 1'b0, b_abort = 1'b0;
    logic [4:0]  b_len = '0;
    logic        b_rd;
    logic [3:0]  b_addr;
    logic [7:0]  b_rdata = '0;
    logic [15:0] b_data, b_cs;
    logic        b_stb, b_busy, b_done, b_err;
    logic [4:0]  b_wc;

    bitstream_self_writer #(.DATA_W(16), .ADDR_W(4), .BIG_ENDIAN(1'b0)) dut_b (
        .CLK(CLK), .resetn(resetn), .start(b_start), .abort(b_abort), .length(b_len),
        .mem_rd(b_rd), .mem_addr(b_addr), .mem_rdata(b_rdata),
        .SelfWriteData(b_data), .SelfWriteStrobe(b_stb), .busy(b_busy), .done(b_done),
        .error(b_err), .word_count(b_wc), .checksum(b_cs)
    );

    // instance C: SETUP_CYCLES=1, GAP_CYCLES=0
    logic        c_start = 1'b0, c_abort = 1'b0;
    logic [14:0] c_len = '0;
    logic        c_rd;
    logic [13:0] c_addr;
    logic [7:0]  c_rdata = '0;
    logic [31:0] c_data, c_cs;
    logic        c_stb, c_busy, c_done, c_err;
    logic [14:0] c_wc;

    bitstream_self_writer #(.SETUP_CYCLES(1), .GAP_CYCLES(0)) dut_c (
        .CLK(CLK), .resetn(resetn), .start(c_start), .abort(c_abort), .length(c_len),
        .mem_rd(c_rd), .mem_addr(c_addr), .mem_rdata(c_rdata),
        .SelfWriteData(c_data), .SelfWriteStrobe(c_stb), .busy(c_busy), .done(c_done),
        .error(c_err), .word_count(c_wc), .checksum(c_cs)
    );

    // synchronous byte memories, data valid exactly one cycle after a read
    always @(posedge CLK) a_rdata <= a_rd ? mem_a[a_addr[7:0]] : 8'hEE;
    always @(posedge CLK) b_rdata <= b_rd ? mem_b[b_addr] : 8'hEE;
    always @(posedge CLK) c_rdata <= c_rd ? mem_a[c_addr[7:0]] : 8'hEE;

    // scoreboard monitors
    always @(negedge CLK) begin
        if (a_stb === 1'b1) begin
            n_cmp++;
            if (qa.size() == 0) begin
                n_bad++;
                $display("FAIL a_strobe: unexpected strobe data=%h at cycle %0d, required none", a_data, cyc);
            end else begin
                ma = qa.pop_front();
                if (a_data !== ma.data || cyc != ma.at) begin
                    n_bad++;
                    $display("FAIL a_strobe: got %h at cycle %0d, required %h at cycle %0d", a_data, cyc, ma.data, ma.at);
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (b_stb === 1'b1) begin
            n_cmp++;
            if (qb.size() == 0) begin
                n_bad++;
                $display("FAIL b_strobe: unexpected strobe data=%h at cycle %0d, required none", b_data, cyc);
            end else begin
                mb = qb.pop_front();
                if ({16'h0, b_data} !== mb.data || cyc != mb.at) begin
                    n_bad++;
                    $display("FAIL b_strobe: got %h at cycle %0d, required %h at cycle %0d", b_data, cyc, mb.data, mb.at);
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (c_stb === 1'b1) begin
            n_cmp++;
            if (qc.size() == 0) begin
                n_bad++;
                $display("FAIL c_strobe: unexpected strobe data=%h at cycle %0d, required none", c_data, cyc);
            end else begin
                mc = qc.pop_front();
                if (c_data !== mc.data || cyc != mc.at) begin
                    n_bad++;
                    $display("FAIL c_strobe: got %h at cycle %0d, required %h at cycle %0d", c_data, cyc, mc.data, mc.at);
                end
            end
        end
    end

    function automatic logic [31:0] word_be(input int base);
        return {mem_a[base], mem_a[base+1], mem_a[base+2], mem_a[base+3]};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_a(input int words, input int s, input int first, input int period);
        exp_t e;
        for (int i = 0; i < words; i++) begin
            e.data = word_be(4 * i);
            e.at   = s + first + period * i;
            qa.push_back(e);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if ({a_busy, a_done, a_err, a_stb, a_rd} !== 5'b0 || a_data !== '0 || a_wc !== '0 || a_cs !== '0 || a_addr !== '0) begin
            n_bad++;
            $display("FAIL reset_a: busy=%b done=%b err=%b stb=%b rd=%b data=%h wc=%0d cs=%h addr=%h, required all 0",
                     a_busy, a_done, a_err, a_stb, a_rd, a_data, a_wc, a_cs, a_addr);
        end
        n_cmp++;
        if ({b_busy, b_done, b_err, b_stb, b_rd} !== 5'b0 || b_data !== '0 || b_wc !== '0 || b_cs !== '0) begin
            n_bad++;
            $display("FAIL reset_b: busy=%b data=%h wc=%0d cs=%h, required all 0", b_busy, b_data, b_wc, b_cs);
        end
        n_cmp++;
        if ({c_busy, c_done, c_err, c_stb, c_rd} !== 5'b0 || c_data !== '0 || c_wc !== '0 || c_cs !== '0) begin
            n_bad++;
            $display("FAIL reset_c: busy=%b data=%h wc=%0d cs=%h, required all 0", c_busy, c_data, c_wc, c_cs);
        end
        a_len = 15'd16;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        n_cmp++;
        if (a_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_wins_start: busy=%b, required 0", a_busy);
        end
        resetn = 1'b1;
        tick();
        n_cmp++;
        if (a_busy !== 1'b0 || a_rd !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_start_dropped: busy=%b rd=%b, required 0 0", a_busy, a_rd);
        end
    endtask

    task automatic test_basic_load();
        int s, d, first_rd;
        logic [13:0] first_addr;
        s = cyc;
        a_len = 15'd16;
        a_start = 1'b1;
        push_a(4, s, 8, 10);
        tick();
        a_start = 1'b0;
        d = -1;
        first_rd = -1;
        first_addr = '1;
        for (int k = 0; k < 80 && d < 0; k++) begin
            @(negedge CLK);
            if (a_rd === 1'b1 && first_rd < 0) begin
                first_rd = cyc;
                first_addr = a_addr;
            end
            if (a_done === 1'b1) d = cyc;
        end
        n_cmp++;
        if (first_rd != s + 1 || first_addr !== 14'd0) begin
            n_bad++;
            $display("FAIL basic_first_read: got cycle %0d addr %0d, required cycle %0d addr 0", first_rd, first_addr, s + 1);
        end
        n_cmp++;
        if (d != s + 39) begin
            n_bad++;
            $display("FAIL basic_done_cycle: got %0d, required %0d", d, s + 39);
        end
        n_cmp++;
        if (a_wc !== 15'd4 || a_cs !== 32'h181C2024) begin
            n_bad++;
            $display("FAIL basic_counters: wc=%0d cs=%h, required 4 181c2024", a_wc, a_cs);
        end
        @(negedge CLK);
        n_cmp++;
        if (a_busy !== 1'b0 || a_done !== 1'b0 || qa.size() != 0) begin
            n_bad++;
            $display("FAIL basic_end: busy=%b done=%b pending=%0d, required 0 0 0", a_busy, a_done, qa.size());
        end
    endtask

    task automatic test_bad_length();
        logic [14:0] bad [3];
        int s, err_at, err_n, act;
        bad[0] = 15'd6;
        bad[1] = 15'd0;
        bad[2] = 15'd16388;
        for (int j = 0; j < 3; j++) begin
            tick();
            s = cyc;
            a_len = bad[j];
            a_start = 1'b1;
            tick();
            a_start = 1'b0;
            err_at = -1;
            err_n = 0;
            act = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge CLK);
                if (a_err === 1'b1) begin
                    err_n++;
                    err_at = cyc;
                end
                if (a_busy !== 1'b0 || a_rd !== 1'b0) act++;
            end
            n_cmp++;
            if (err_n != 1 || err_at != s + 1) begin
                n_bad++;
                $display("FAIL bad_len_error len=%0d: pulses=%0d at %0d, required 1 at %0d", bad[j], err_n, err_at, s + 1);
            end
            n_cmp++;
            if (act != 0) begin
                n_bad++;
                $display("FAIL bad_len_activity len=%0d: busy/rd cycles=%0d, required 0", bad[j], act);
            end
        end
        n_cmp++;
        if (a_wc !== 15'd4 || a_cs !== 32'h181C2024) begin
            n_bad++;
            $display("FAIL bad_len_counters: wc=%0d cs=%h, required 4 181c2024", a_wc, a_cs);
        end
    endtask

    task automatic test_abort();
        int s, err_at, err_n, dn, bz;
        tick();
        s = cyc;
        a_len = 15'd64;
        a_start = 1'b1;
        push_a(2, s, 8, 10);
        tick();
        a_start = 1'b0;
        while (cyc < s + 26) tick();
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        err_at = -1;
        err_n = 0;
        dn = 0;
        bz = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge CLK);
            if (a_err === 1'b1) begin
                err_n++;
                err_at = cyc;
            end
            if (a_done !== 1'b0) dn++;
            if (a_busy !== 1'b0) bz++;
        end
        n_cmp++;
        if (err_n != 1 || err_at != s + 27) begin
            n_bad++;
            $display("FAIL abort_error: pulses=%0d at %0d, required 1 at %0d", err_n, err_at, s + 27);
        end
        n_cmp++;
        if (dn != 0 || bz != 0) begin
            n_bad++;
            $display("FAIL abort_idle: done cycles=%0d busy cycles=%0d, required 0 0", dn, bz);
        end
        n_cmp++;
        if (a_wc !== 15'd2 || a_cs !== 32'h0406080A || qa.size() != 0) begin
            n_bad++;
            $display("FAIL abort_partial: wc=%0d cs=%h pending=%0d, required 2 0406080a 0", a_wc, a_cs, qa.size());
        end
    endtask

    task automatic test_reset_in_gap();
        int s, d;
        tick();
        s = cyc;
        a_len = 15'd16;
        a_start = 1'b1;
        push_a(1, s, 8, 10);
        tick();
        a_start = 1'b0;
        while (cyc < s + 9) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if ({a_busy, a_done, a_err, a_stb, a_rd} !== 5'b0 || a_data !== '0 || a_wc !== '0 || a_cs !== '0 || a_addr !== '0) begin
            n_bad++;
            $display("FAIL gap_reset: busy=%b done=%b err=%b stb=%b rd=%b data=%h wc=%0d cs=%h addr=%h, required all 0",
                     a_busy, a_done, a_err, a_stb, a_rd, a_data, a_wc, a_cs, a_addr);
        end
        n_cmp++;
        if (qa.size() != 0) begin
            n_bad++;
            $display("FAIL gap_reset_first_word: pending=%0d, required 0", qa.size());
        end
        tick();
        s = cyc;
        a_start = 1'b1;
        push_a(4, s, 8, 10);
        tick();
        a_start = 1'b0;
        d = -1;
        for (int k = 0; k < 80 && d < 0; k++) begin
            @(negedge CLK);
            if (a_done === 1'b1) d = cyc;
        end
        n_cmp++;
        if (d != s + 39 || a_wc !== 15'd4 || a_cs !== 32'h181C2024) begin
            n_bad++;
            $display("FAIL gap_reset_reload: done at %0d wc=%0d cs=%h, required %0d 4 181c2024", d, a_wc, a_cs, s + 39);
        end
    endtask

    task automatic test_start_ignored();
        int s, d;
        tick();
        s = cyc;
        a_len = 15'd16;
        a_start = 1'b1;
        a_abort = 1'b1;
        push_a(4, s, 8, 10);
        tick();
        a_start = 1'b0;
        a_abort = 1'b0;
        while (cyc < s + 5) tick();
        a_len = 15'd8;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        d = -1;
        for (int k = 0; k < 80 && d < 0; k++) begin
            @(negedge CLK);
            if (a_done === 1'b1) d = cyc;
        end
        n_cmp++;
        if (d != s + 39 || a_wc !== 15'd4 || qa.size() != 0) begin
            n_bad++;
            $display("FAIL start_ignored: done at %0d wc=%0d pending=%0d, required %0d 4 0", d, a_wc, qa.size(), s + 39);
        end
    endtask

    task automatic test_back_to_back();
        int s, d;
        @(negedge CLK);
        s = cyc;
        a_len = 15'd16;
        a_start = 1'b1;
        push_a(4, s, 8, 10);
        tick();
        a_start = 1'b0;
        n_cmp++;
        if (a_busy !== 1'b1 || a_wc !== 15'd0 || a_cs !== 32'h0) begin
            n_bad++;
            $display("FAIL b2b_start: busy=%b wc=%0d cs=%h, required 1 0 0", a_busy, a_wc, a_cs);
        end
        d = -1;
        for (int k = 0; k < 80 && d < 0; k++) begin
            @(negedge CLK);
            if (a_done === 1'b1) d = cyc;
        end
        n_cmp++;
        if (d != s + 39 || a_cs !== 32'h181C2024 || qa.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_done: done at %0d cs=%h pending=%0d, required %0d 181c2024 0", d, a_cs, qa.size(), s + 39);
        end
    endtask

    task automatic test_little_endian();
        int s, d;
        exp_t e;
        tick();
        s = cyc;
        b_len = 5'd2;
        b_start = 1'b1;
        e.data = 32'h0000BBAA;
        e.at = s + 6;
        qb.push_back(e);
        tick();
        b_start = 1'b0;
        d = -1;
        for (int k = 0; k < 30 && d < 0; k++) begin
            @(negedge CLK);
            if (b_done === 1'b1) d = cyc;
        end
        n_cmp++;
        if (d != s + 7 || b_wc !== 5'd1 || b_cs !== 16'hBBAA || qb.size() != 0) begin
            n_bad++;
            $display("FAIL le16: done at %0d wc=%0d cs=%h pending=%0d, required %0d 1 bbaa 0", d, b_wc, b_cs, qb.size(), s + 7);
        end
    endtask

    task automatic test_max_length();
        int s, d, reads, err_n;
        logic [3:0] last_addr;
        logic [15:0] sum;
        exp_t e;
        tick();
        s = cyc;
        b_len = 5'd16;
        b_start = 1'b1;
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            e.data = {16'h0, mem_b[2*i+1], mem_b[2*i]};
            e.at = s + 6 + 8 * i;
            sum = sum + e.data[15:0];
            qb.push_back(e);
        end
        tick();
        b_start = 1'b0;
        d = -1;
        reads = 0;
        last_addr = '0;
        for (int k = 0; k < 120 && d < 0; k++) begin
            @(negedge CLK);
            if (b_rd === 1'b1) begin
                reads++;
                last_addr = b_addr;
            end
            if (b_done === 1'b1) d = cyc;
        end
        n_cmp++;
        if (d != s + 63 || reads != 16 || last_addr !== 4'd15) begin
            n_bad++;
            $display("FAIL max_len_run: done at %0d reads=%0d last addr=%0d, required %0d 16 15", d, reads, last_addr, s + 63);
        end
        n_cmp++;
        if (b_wc !== 5'd8 || b_cs !== sum || qb.size() != 0) begin
            n_bad++;
            $display("FAIL max_len_counters: wc=%0d cs=%h pending=%0d, required 8 %h 0", b_wc, b_cs, qb.size(), sum);
        end
        tick();
        s = cyc;
        b_len = 5'd18;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        err_n = 0;
        reads = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            if (b_err === 1'b1 && cyc == s + 1) err_n++;
            if (b_busy !== 1'b0 || b_rd !== 1'b0) reads++;
        end
        n_cmp++;
        if (err_n != 1 || reads != 0 || b_wc !== 5'd8) begin
            n_bad++;
            $display("FAIL over_max_len: error at s+1=%0d activity=%0d wc=%0d, required 1 0 8", err_n, reads, b_wc);
        end
    endtask

    task automatic test_fast_pacing();
        int s, d;
        logic [31:0] sum;
        exp_t e;
        tick();
        s = cyc;
        c_len = 15'd12;
        c_start = 1'b1;
        sum = '0;
        for (int i = 0; i < 3; i++) begin
            e.data = word_be(4 * i);
            e.at = s + 7 + 7 * i;
            sum = sum + e.data;
            qc.push_back(e);
        end
        tick();
        c_start = 1'b0;
        d = -1;
        for (int k = 0; k < 60 && d < 0; k++) begin
            @(negedge CLK);
            if (c_done === 1'b1) d = cyc;
        end
        n_cmp++;
        if (d != s + 22 || c_wc !== 15'd3 || c_cs !== sum || qc.size() != 0) begin
            n_bad++;
            $display("FAIL fast_pacing: done at %0d wc=%0d cs=%h pending=%0d, required %0d 3 %h 0",
                     d, c_wc, c_cs, qc.size(), s + 22, sum);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_a[i] = (i < 16) ? 8'(i) : 8'(i * 37 + 11);
        for (int i = 0; i < 16; i++) mem_b[i] = 8'((i * 17) ^ 8'hC3);
        mem_b[0] = 8'hAA;
        mem_b[1] = 8'hBB;
        test_reset();
        test_basic_load();
        test_bad_length();
        test_abort();
        test_reset_in_gap();
        test_start_ignored();
        test_back_to_back();
        test_little_endian();
        test_max_length();
        test_fast_pacing();
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/bitstream_self_writer.md
# bitstream_self_writer

Synthesizable replacement for the bench-side bitstream loop: streams a byte-addressed bitstream image from a synchronous byte memory into the fabric configuration port as paced `SelfWriteData`/`SelfWriteStrobe` words. It sits between an on-chip bitstream buffer (or SPI-filled RAM) and the eFPGA top-level self-write inputs. It is generalised in word width, byte order and strobe pacing. It adds length checking, abort, word counting and a running checksum for post-load verification.

## Interface
- `DATA_W`, 32, configuration word width; multiple of 8, 8..64; `NB = DATA_W/8` bytes per word
- `ADDR_W`, 14, byte address width; max image `2^ADDR_W` bytes
- `SETUP_CYCLES`, 2, cycles data is stable before strobe (>=1)
- `GAP_CYCLES`, 2, cycles after strobe before the next fetch begins (>=0)
- `BIG_ENDIAN`, 1, 1: lowest byte address goes to MSB lane; 0: to LSB lane
- `CLK`  in  1  single clock, rising edge
- `resetn`  in  1  synchronous reset, active-low
- `start`  in  1  one-cycle pulse; starts a load when idle, ignored while `busy`
- `abort`  in  1  stops an active load at the next edge
- `length`  in  ADDR_W+1  image length in bytes, sampled on accepted `start`
- `mem_rd`  out  1  byte read enable
- `mem_addr`  out  ADDR_W  byte address
- `mem_rdata`  in  8  read data, valid exactly 1 cycle after `mem_rd`
- `SelfWriteData`  out  DATA_W  configuration word
- `SelfWriteStrobe`  out  1  one-cycle write strobe
- `busy`  out  1  high from accepted `start` until return to IDLE
- `done`  out  1  one-cycle pulse on successful completion
- `error`  out  1  one-cycle pulse on rejected length or abort
- `word_count`  out  ADDR_W+1  words strobed in current/last load
- `checksum`  out  DATA_W  sum mod 2^DATA_W of all strobed words

## Operation
- Reset (`resetn` low at an edge): state IDLE. All outputs 0, including `SelfWriteData`, `word_count` and `checksum`. Reset wins over `start`/`abort` in the same cycle and terminates a load mid-word with no strobe.
- States: IDLE, FETCH, SETUP, STROBE, GAP, DONE.
- IDLE + `start`:
  - `length` of 0, not a multiple of NB, or > 2^ADDR_W: pulse `error` next cycle, stay IDLE, `busy` stays 0, counters untouched.
  - Otherwise: clear `word_count`/`checksum`, address pointer = 0, enter FETCH.
- FETCH: issue `mem_rd` with consecutive addresses for NB cycles. Capture `mem_rdata` one cycle after each read into the byte lane selected by `BIG_ENDIAN`. After the last byte is captured (NB+1 cycles in FETCH), load the assembled word into `SelfWriteData` and enter SETUP.
- SETUP: hold for SETUP_CYCLES cycles, then enter STROBE.
- STROBE: `SelfWriteStrobe`=1 for exactly one cycle. Same edge: `word_count`+1, `checksum` += `SelfWriteData`. If this was the last word (pointer == length), enter DONE. Otherwise enter GAP, or FETCH if GAP_CYCLES=0.
- GAP: hold GAP_CYCLES cycles, then enter FETCH.
- DONE: `done`=1 for one cycle, `busy` drops on the same edge, then IDLE.
- `SelfWriteData` changes only on entry to SETUP or on reset. It is held through STROBE, GAP and the next FETCH.
- `abort` while busy: next edge → IDLE, `error` pulses, no strobe in that cycle or later, `word_count`/`checksum` keep their partial values. `abort` in IDLE is ignored. `abort` and `start` together in IDLE: start is processed and abort ignored.
- `mem_rd` is 0 outside FETCH. `mem_addr` holds its last value when not reading.

## Timing
- Word period = (NB+1) + SETUP_CYCLES + 1 + GAP_CYCLES cycles; 10 cycles at defaults.
- First `mem_rd` is in the cycle after the accepted `start`. First strobe is NB+1+SETUP_CYCLES+1 cycles after `start`; 8 at defaults.
- `done` is asserted 1 cycle after the last strobe.
- Total load = words × period − GAP_CYCLES + 2 cycles from `start` to `done` inclusive.
- Address wrap: impossible by length check; length = 2^ADDR_W reads addresses 0..2^ADDR_W−1 once.

## Test plan
- Defaults, memory bytes 0x00..0x0F, `length`=16 → 4 strobes with data 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F, spaced 10 cycles; `done` 1 cycle after the 4th strobe; `word_count`=4, `checksum`=0x181C2024.
- `BIG_ENDIAN`=0, `DATA_W`=16, bytes 0xAA,0xBB, `length`=2 → single strobe with 0xBBAA; `checksum`=0xBBAA.
- `length`=6 at DATA_W=32, and `length`=0 → `error` pulse, no `mem_rd`, `busy` never high.
- `abort` asserted in SETUP of word 3 of a 16-word load → no further strobes, `error` pulse, `word_count`=2, `done` stays 0.
- `resetn` low for 1 cycle during GAP → all outputs 0 next cycle; a new `start` then runs a full load correctly.
- `start` re-pulsed while busy → ignored; `length` change during a load has no effect; `SETUP_CYCLES`=1, `GAP_CYCLES`=0 gives a 7-cycle word period.
